// File: rtl/issue_queue_dispatcher.sv
// Dual-issue in-order issue queue: circular FIFO feeding a full-function lane (oldest)
// and a restricted lane (second-oldest), gated by a per-register multi-cycle scoreboard.
module issue_queue_dispatcher #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAYLOAD_W = 192,
  parameter int unsigned MC_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 stall,
  input  logic [1:0]           in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_ctrl0,
  input  logic [31:0]          in_ctrl1,
  input  logic [4:0]           in_rk0,
  input  logic [4:0]           in_rk1,
  input  logic [4:0]           in_rj0,
  input  logic [4:0]           in_rj1,
  input  logic [4:0]           in_rd0,
  input  logic [4:0]           in_rd1,
  input  logic [PAYLOAD_W-1:0] in_payload0,
  input  logic [PAYLOAD_W-1:0] in_payload1,
  output logic                 iss_valid1,
  output logic [31:0]          iss_ctrl1,
  output logic [4:0]           iss_rk1,
  output logic [4:0]           iss_rj1,
  output logic [4:0]           iss_rd1,
  output logic [PAYLOAD_W-1:0] iss_payload1,
  output logic                 iss_valid0,
  output logic [31:0]          iss_ctrl0,
  output logic [4:0]           iss_rk0,
  output logic [4:0]           iss_rj0,
  output logic [4:0]           iss_rd0,
  output logic [PAYLOAD_W-1:0] iss_payload0,
  output logic [31:0]          raw_stall_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [1:0]    McLat  = 2'(MC_LAT);

  typedef logic [31:0][1:0] sb_t;

  function automatic logic f_blocked(input sb_t sb, input logic [4:0] r);
    return (r != 5'd0) && (sb[r] != 2'd0);
  endfunction

  function automatic logic f_ready(input sb_t sb, input logic [31:0] ctrl, input logic [4:0] rk,
                                   input logic [4:0] rj, input logic [4:0] rd);
    return !f_blocked(sb, rk) && !f_blocked(sb, rj) && !(ctrl[29] && f_blocked(sb, rd));
  endfunction

  function automatic logic f_mc_writer(input logic [31:0] ctrl, input logic [4:0] rd);
    return (ctrl[3:0] inside {4'd2, 4'd3, 4'd4, 4'd5}) && ctrl[6] && (rd != 5'd0);
  endfunction

  logic [31:0]          r_ctrl    [DEPTH];
  logic [4:0]           r_rk      [DEPTH];
  logic [4:0]           r_rj      [DEPTH];
  logic [4:0]           r_rd      [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  sb_t           r_sb;
  logic [31:0]   r_raw;

  logic [PW-1:0] w_h1;
  logic [PW-1:0] w_tail1;
  logic          w_head_ready;
  logic          w_h1_ready;
  logic          w_h1_type_ok;
  logic          w_dep;
  logic          w_iss1;
  logic          w_iss0;
  logic          w_enq;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic          w_raw_inc;
  sb_t           w_sb_d;

  assign in_ready = (DepthC - r_count) >= CW'(2);
  assign w_enq    = in_ready && (|in_valid);
  assign w_push   = w_enq ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;
  assign w_tail1  = r_tail + PW'(in_valid[0]);
  assign w_h1     = r_head + PW'(1);

  assign w_head_ready = f_ready(r_sb, r_ctrl[r_head], r_rk[r_head], r_rj[r_head], r_rd[r_head]);
  assign w_h1_ready   = f_ready(r_sb, r_ctrl[w_h1], r_rk[w_h1], r_rj[w_h1], r_rd[w_h1]);
  assign w_h1_type_ok = r_ctrl[w_h1][3:0] inside {4'd0, 4'd1, 4'd4, 4'd7, 4'd8, 4'd9};

  // Same-cycle RAW between the pair: the second instruction must wait for the head's result.
  assign w_dep = r_ctrl[r_head][6] && (r_rd[r_head] != 5'd0) &&
                 ((r_rd[r_head] == r_rk[w_h1]) || (r_rd[r_head] == r_rj[w_h1]) ||
                  (r_ctrl[w_h1][29] && (r_rd[r_head] == r_rd[w_h1])));

  assign w_iss1 = (r_count != '0) && w_head_ready;
  assign w_iss0 = w_iss1 && (r_count >= CW'(2)) && w_h1_type_ok && w_h1_ready && !w_dep;

  assign w_pop     = stall ? 2'd0 : ({1'b0, w_iss1} + {1'b0, w_iss0});
  assign w_raw_inc = (r_count != '0) && !stall && !w_head_ready;

  always_comb begin
    w_sb_d = r_sb;
    if (!stall) begin
      for (int r = 0; r < 32; r++) begin
        if (r_sb[r] != 2'd0) w_sb_d[r] = r_sb[r] - 2'd1;
      end
      if (w_iss1 && f_mc_writer(r_ctrl[r_head], r_rd[r_head])) w_sb_d[r_rd[r_head]] = McLat;
      if (w_iss0 && f_mc_writer(r_ctrl[w_h1], r_rd[w_h1]))     w_sb_d[r_rd[w_h1]]   = McLat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_sb    <= '0;
      r_raw   <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_sb    <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_sb    <= w_sb_d;
      if (w_raw_inc) r_raw <= r_raw + 32'd1;
    end
  end

  // Entry storage needs no reset: nothing is visible unless occupancy covers it.
  always_ff @(posedge clk) begin
    if (w_enq && !flush) begin
      if (in_valid[0]) begin
        r_ctrl[r_tail]    <= in_ctrl0;
        r_rk[r_tail]      <= in_rk0;
        r_rj[r_tail]      <= in_rj0;
        r_rd[r_tail]      <= in_rd0;
        r_payload[r_tail] <= in_payload0;
      end
      if (in_valid[1]) begin
        r_ctrl[w_tail1]    <= in_ctrl1;
        r_rk[w_tail1]      <= in_rk1;
        r_rj[w_tail1]      <= in_rj1;
        r_rd[w_tail1]      <= in_rd1;
        r_payload[w_tail1] <= in_payload1;
      end
    end
  end

  always_comb begin
    iss_valid1   = 1'b0;
    iss_ctrl1    = '0;
    iss_rk1      = '0;
    iss_rj1      = '0;
    iss_rd1      = '0;
    iss_payload1 = '0;
    iss_valid0   = 1'b0;
    iss_ctrl0    = '0;
    iss_rk0      = '0;
    iss_rj0      = '0;
    iss_rd0      = '0;
    iss_payload0 = '0;
    if (w_iss1) begin
      iss_valid1   = 1'b1;
      iss_ctrl1    = r_ctrl[r_head];
      iss_rk1      = r_rk[r_head];
      iss_rj1      = r_rj[r_head];
      iss_rd1      = r_rd[r_head];
      iss_payload1 = r_payload[r_head];
    end
    if (w_iss0) begin
      iss_valid0   = 1'b1;
      iss_ctrl0    = r_ctrl[w_h1];
      iss_rk0      = r_rk[w_h1];
      iss_rj0      = r_rj[w_h1];
      iss_rd0      = r_rd[w_h1];
      iss_payload0 = r_payload[w_h1];
    end
  end

  assign raw_stall_count = r_raw;

endmodule

// File: tb/tb_issue_queue_dispatcher.sv
// Randomized bench for issue_queue_dispatcher against a queue-based reference model,
// with directed scenarios for pairing, RAW stalls, full/wrap, flush and async reset.
module tb_issue_queue_dispatcher;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned PAYLOAD_W = 192;
  localparam int unsigned MC_LAT    = 1;

  typedef struct packed {
    logic [31:0]          ctrl;
    logic [4:0]           rk;
    logic [4:0]           rj;
    logic [4:0]           rd;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;

  logic       clk = 1'b0;
  logic       rstn, flush, stall;
  logic [1:0] in_valid;
  ent_t       s0, s1;
  logic       in_ready;
  logic       iss_valid1, iss_valid0;
  logic [31:0] iss_ctrl1, iss_ctrl0, raw_stall_count;
  logic [4:0] iss_rk1, iss_rj1, iss_rd1, iss_rk0, iss_rj0, iss_rd0;
  logic [PAYLOAD_W-1:0] iss_payload1, iss_payload0;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        m_q[$];
  int          m_sb[32];
  int unsigned m_raw;

  always #5 clk = ~clk;

  issue_queue_dispatcher #(
    .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .MC_LAT(MC_LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl0(s0.ctrl), .in_ctrl1(s1.ctrl),
    .in_rk0(s0.rk), .in_rk1(s1.rk), .in_rj0(s0.rj), .in_rj1(s1.rj),
    .in_rd0(s0.rd), .in_rd1(s1.rd),
    .in_payload0(s0.pl), .in_payload1(s1.pl),
    .iss_valid1(iss_valid1), .iss_ctrl1(iss_ctrl1), .iss_rk1(iss_rk1), .iss_rj1(iss_rj1),
    .iss_rd1(iss_rd1), .iss_payload1(iss_payload1),
    .iss_valid0(iss_valid0), .iss_ctrl0(iss_ctrl0), .iss_rk0(iss_rk0), .iss_rj0(iss_rj0),
    .iss_rd0(iss_rd0), .iss_payload0(iss_payload0),
    .raw_stall_count(raw_stall_count)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit blk(input logic [4:0] r);
    return (r != 0) && (m_sb[r] != 0);
  endfunction

  function automatic bit rdy(input ent_t e);
    return !blk(e.rk) && !blk(e.rj) && !(e.ctrl[29] && blk(e.rd));
  endfunction

  function automatic bit mcw(input ent_t e);
    int t = int'(e.ctrl[3:0]);
    return (t >= 2 && t <= 5) && e.ctrl[6] && (e.rd != 0);
  endfunction

  function automatic bit lane0_ok(input ent_t e);
    int t = int'(e.ctrl[3:0]);
    return t == 0 || t == 1 || t == 4 || t == 7 || t == 8 || t == 9;
  endfunction

  function automatic bit reads(input ent_t e, input logic [4:0] r);
    return (e.rk == r) || (e.rj == r) || (e.ctrl[29] && e.rd == r);
  endfunction

  function automatic bit exp_i1();
    return m_q.size() > 0 && rdy(m_q[0]);
  endfunction

  function automatic bit exp_i0();
    if (!exp_i1() || m_q.size() < 2) return 0;
    if (!lane0_ok(m_q[1]) || !rdy(m_q[1])) return 0;
    return !(m_q[0].ctrl[6] && m_q[0].rd != 0 && reads(m_q[1], m_q[0].rd));
  endfunction

  function automatic bit exp_ready();
    return (DEPTH - m_q.size()) >= 2;
  endfunction

  task automatic model_reset();
    m_q.delete();
    foreach (m_sb[r]) m_sb[r] = 0;
    m_raw = 0;
  endtask

  task automatic model_update();
    bit i1 = exp_i1();
    bit i0 = exp_i0();
    bit rd_ok = exp_ready();
    if (flush) begin
      m_q.delete();
      foreach (m_sb[r]) m_sb[r] = 0;
      return;
    end
    if (!stall) begin
      if (m_q.size() > 0 && !rdy(m_q[0])) m_raw++;
      foreach (m_sb[r]) if (m_sb[r] > 0) m_sb[r]--;
      if (i1) begin
        ent_t e = m_q.pop_front();
        if (mcw(e)) m_sb[e.rd] = MC_LAT;
      end
      if (i0) begin
        ent_t e = m_q.pop_front();
        if (mcw(e)) m_sb[e.rd] = MC_LAT;
      end
    end
    if (rd_ok) begin
      if (in_valid[0]) m_q.push_back(s0);
      if (in_valid[1]) m_q.push_back(s1);
    end
  endtask

  task automatic compare_all(input string tag);
    ent_t e1 = '0;
    ent_t e0 = '0;
    if (exp_i1()) e1 = m_q[0];
    if (exp_i0()) e0 = m_q[1];
    check_eq({tag, ".in_ready"}, in_ready, exp_ready());
    check_eq({tag, ".v1"}, iss_valid1, exp_i1());
    check_eq({tag, ".v0"}, iss_valid0, exp_i0());
    check_eq({tag, ".lane1"}, {iss_ctrl1, iss_rk1, iss_rj1, iss_rd1, iss_payload1}, e1);
    check_eq({tag, ".lane0"}, {iss_ctrl0, iss_rk0, iss_rj0, iss_rd0, iss_payload0}, e0);
    check_eq({tag, ".raw"}, raw_stall_count, m_raw);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [1:0] v, input ent_t a, input ent_t b,
                      input logic st, input logic fl);
    in_valid = v; s0 = a; s1 = b; stall = st; flush = fl;
    #1;
    compare_all("cyc");
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic ent_t mk(input int t, input bit rw, input int rd, input int rk,
                              input int rj, input bit rdsrc);
    ent_t e = '0;
    e.ctrl[3:0] = 4'(t);
    e.ctrl[6]   = rw;
    e.ctrl[29]  = rdsrc;
    e.rd = 5'(rd); e.rk = 5'(rk); e.rj = 5'(rj);
    for (int i = 0; i < PAYLOAD_W; i += 32) e.pl[i +: 32] = $urandom;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e = mk($urandom_range(0, 11), 1'($urandom), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom));
    e.ctrl[31:30] = 2'($urandom);
    e.ctrl[28:7]  = 22'($urandom);
    return e;
  endfunction

  ent_t nop = '0;
  int unsigned raw0;

  initial begin
    rstn = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 2'b00; s0 = '0; s1 = '0;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Independent ALU pair issues together next cycle.
    step(2'b11, mk(0, 1, 1, 0, 0, 0), mk(0, 1, 2, 3, 0, 0), 0, 0);
    check_eq("pair.v1", iss_valid1, 1'b1);
    check_eq("pair.rd1", iss_rd1, 5'd1);
    check_eq("pair.v0", iss_valid0, 1'b1);
    check_eq("pair.rd0", iss_rd0, 5'd2);
    step(2'b00, nop, nop, 0, 0);
    check_eq("pair.empty", iss_valid1, 1'b0);

    // Load then dependent add: one RAW stall cycle.
    raw0 = m_raw;
    step(2'b11, mk(5, 1, 5, 0, 0, 0), mk(0, 1, 6, 5, 0, 0), 0, 0);
    check_eq("load.v1", iss_valid1, 1'b1);
    check_eq("load.v0", iss_valid0, 1'b0);
    step(2'b00, nop, nop, 0, 0);
    check_eq("load.blocked", iss_valid1, 1'b0);
    step(2'b00, nop, nop, 0, 0);
    check_eq("load.add_v1", iss_valid1, 1'b1);
    check_eq("load.add_rd", iss_rd1, 5'd6);
    check_eq("load.raw", raw_stall_count, 32'(raw0 + 1));
    step(2'b00, nop, nop, 0, 0);

    // Intra-pair RAW: dependent instruction waits for lane 1 next cycle.
    step(2'b11, mk(0, 1, 4, 0, 0, 0), mk(0, 1, 7, 4, 0, 0), 0, 0);
    check_eq("dep.v0", iss_valid0, 1'b0);
    step(2'b00, nop, nop, 0, 0);
    check_eq("dep.rd1", iss_rd1, 5'd7);
    check_eq("dep.v0b", iss_valid0, 1'b0);
    step(2'b00, nop, nop, 0, 0);

    // Fill to 7 under stall, then drain; then fill to 8 and drain across the wrap.
    for (int k = 0; k < 3; k++)
      step(2'b11, mk(0, 1, 10 + 2 * k, 0, 0, 0), mk(1, 1, 11 + 2 * k, 0, 0, 0), 1, 0);
    step(2'b01, mk(0, 1, 20, 0, 0, 0), nop, 1, 0);
    check_eq("full7.in_ready", in_ready, 1'b0);
    step(2'b11, mk(0, 1, 21, 0, 0, 0), mk(0, 1, 22, 0, 0, 0), 1, 0);
    for (int k = 0; k < 4; k++) step(2'b00, nop, nop, 0, 0);
    check_eq("drain7.empty", iss_valid1, 1'b0);
    for (int k = 0; k < 4; k++)
      step(2'b11, mk(0, 1, 10 + 2 * k, 0, 0, 0), mk(8, 1, 11 + 2 * k, 0, 0, 0), 1, 0);
    check_eq("full8.in_ready", in_ready, 1'b0);
    check_eq("full8.v1", iss_valid1, 1'b1);
    for (int k = 0; k < 4; k++) step(2'b00, nop, nop, 0, 0);
    check_eq("drain8.empty", iss_valid1, 1'b0);
    check_eq("drain8.in_ready", in_ready, 1'b1);

    // Flush at occupancy 5 beats a simultaneous enqueue.
    step(2'b11, rnd_ent(), rnd_ent(), 1, 0);
    step(2'b11, rnd_ent(), rnd_ent(), 1, 0);
    step(2'b01, rnd_ent(), nop, 1, 0);
    step(2'b11, rnd_ent(), rnd_ent(), 0, 1);
    check_eq("flush.v1", iss_valid1, 1'b0);
    check_eq("flush.v0", iss_valid0, 1'b0);
    check_eq("flush.in_ready", in_ready, 1'b1);

    // Asynchronous reset between edges with 3 entries queued.
    step(2'b11, mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), 1, 0);
    step(2'b01, mk(0, 0, 0, 0, 0, 0), nop, 1, 0);
    in_valid = 2'b00; stall = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst.v1", iss_valid1, 1'b0);
    check_eq("arst.v0", iss_valid0, 1'b0);
    check_eq("arst.ctrl1", iss_ctrl1, 32'd0);
    check_eq("arst.in_ready", in_ready, 1'b1);
    check_eq("arst.raw", raw_stall_count, 32'd0);
    model_reset();
    #1;
    rstn = 1'b1;
    @(negedge clk);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      step(2'($urandom), rnd_ent(), rnd_ent(), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
